// File: rtl/tty_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tty_writer
//  Description : Byte-stream terminal writer driving a circular character
//                buffer with cursor, scroll and screen-clear support.
//  Revision    : 1.0
// ============================================================================
module tty_writer #(
    parameter int ROWS           = 24,
    parameter int COLS           = 80,
    parameter int ROW_BITS       = 5,
    parameter int COL_BITS       = 7,
    parameter int ADDR_BITS      = 11,
    parameter bit AUTOWRAP       = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           new_char,
    output logic [ADDR_BITS-1:0] new_char_address,
    output logic                 new_char_wen,
    output logic [ADDR_BITS-1:0] new_first_char,
    output logic                 new_first_char_wen,
    output logic [COL_BITS-1:0]  new_cursor_x,
    output logic [ROW_BITS-1:0]  new_cursor_y,
    output logic                 new_cursor_wen,
    output logic                 bell
);

    localparam logic [1:0] c_IDLE         = 2'd0;
    localparam logic [1:0] c_CLEAR_LINE   = 2'd1;
    localparam logic [1:0] c_CLEAR_SCREEN = 2'd2;

    localparam logic [ADDR_BITS:0]   c_SIZE   = (ADDR_BITS+1)'(ROWS * COLS);
    localparam logic [ADDR_BITS:0]   c_COLS   = (ADDR_BITS+1)'(COLS);
    localparam logic [ADDR_BITS:0]   c_ONE    = (ADDR_BITS+1)'(1);
    localparam logic [COL_BITS-1:0]  c_LAST_X = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0]  c_LAST_Y = ROW_BITS'(ROWS - 1);

    // Sums are at most 2*SIZE-1, so one conditional subtract keeps them in range.
    function automatic logic [ADDR_BITS-1:0] f_wrap_add(input logic [ADDR_BITS-1:0] a,
                                                         input logic [ADDR_BITS:0]   b);
        logic [ADDR_BITS:0] s;
        s = {1'b0, a} + b;
        if (s >= c_SIZE)
            s = s - c_SIZE;
        return s[ADDR_BITS-1:0];
    endfunction

    logic [1:0]           r_state, w_state_next;
    logic                 r_init;
    logic [COL_BITS-1:0]  r_x, w_x;
    logic [ROW_BITS-1:0]  r_y, w_y;
    logic [ADDR_BITS-1:0] r_first, w_first;
    logic [ADDR_BITS-1:0] r_line, w_line;
    logic [ADDR_BITS-1:0] r_clr_addr, w_clr_addr;
    logic [ADDR_BITS:0]   r_clr_cnt, w_clr_cnt;
    logic [7:0]           r_char, w_char;
    logic [ADDR_BITS-1:0] r_addr, w_addr;
    logic                 r_char_wen, w_char_wen;
    logic                 r_first_wen, w_first_wen;
    logic                 r_cursor_wen, w_cursor_wen;
    logic                 r_bell, w_bell;

    logic w_accept, w_is_print, w_lf, w_scroll;

    assign w_accept   = in_valid && in_ready;
    assign w_is_print = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign w_lf       = (in_data == 8'h0A) || (w_is_print && AUTOWRAP && (r_x == c_LAST_X));
    assign w_scroll   = w_lf && (r_y == c_LAST_Y);

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_state <= c_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (!r_init) begin
                    if (CLEAR_ON_RESET)
                        w_state_next = c_CLEAR_SCREEN;
                end else if (w_accept) begin
                    if (in_data == 8'h0C)
                        w_state_next = c_CLEAR_SCREEN;
                    else if (w_scroll)
                        w_state_next = c_CLEAR_LINE;
                end
            end
            c_CLEAR_LINE, c_CLEAR_SCREEN: begin
                if (r_clr_cnt == c_ONE)
                    w_state_next = c_IDLE;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // Output / datapath decode; r_line tracks the buffer address of column 0 on the cursor row.
    always_comb begin
        w_x          = r_x;
        w_y          = r_y;
        w_first      = r_first;
        w_line       = r_line;
        w_clr_addr   = r_clr_addr;
        w_clr_cnt    = r_clr_cnt;
        w_char       = r_char;
        w_addr       = r_addr;
        w_char_wen   = 1'b0;
        w_first_wen  = 1'b0;
        w_cursor_wen = 1'b0;
        w_bell       = 1'b0;
        if (r_state != c_IDLE) begin
            w_char_wen = 1'b1;
            w_char     = 8'h20;
            w_addr     = r_clr_addr;
            w_clr_addr = f_wrap_add(r_clr_addr, c_ONE);
            w_clr_cnt  = r_clr_cnt - c_ONE;
        end else if (!r_init) begin
            if (CLEAR_ON_RESET) begin
                w_first_wen  = 1'b1;
                w_cursor_wen = 1'b1;
                w_clr_addr   = '0;
                w_clr_cnt    = c_SIZE;
            end
        end else if (w_accept) begin
            if (w_is_print) begin
                w_char_wen   = 1'b1;
                w_char       = in_data;
                w_addr       = f_wrap_add(r_line, (ADDR_BITS+1)'(r_x));
                w_cursor_wen = 1'b1;
                if (r_x != c_LAST_X)
                    w_x = r_x + COL_BITS'(1);
                else if (AUTOWRAP)
                    w_x = '0;
            end else begin
                case (in_data)
                    8'h0D: begin
                        w_x          = '0;
                        w_cursor_wen = 1'b1;
                    end
                    8'h08: begin
                        if (r_x != '0)
                            w_x = r_x - COL_BITS'(1);
                        w_cursor_wen = 1'b1;
                    end
                    8'h0C: begin
                        w_first      = '0;
                        w_line       = '0;
                        w_x          = '0;
                        w_y          = '0;
                        w_first_wen  = 1'b1;
                        w_cursor_wen = 1'b1;
                        w_clr_addr   = '0;
                        w_clr_cnt    = c_SIZE;
                    end
                    8'h07:   w_bell = 1'b1;
                    default: ;
                endcase
            end
            if (w_lf) begin
                w_cursor_wen = 1'b1;
                if (r_y != c_LAST_Y) begin
                    w_y    = r_y + ROW_BITS'(1);
                    w_line = f_wrap_add(r_line, c_COLS);
                end else begin
                    // The old top line becomes the new bottom line and is blanked.
                    w_first     = f_wrap_add(r_first, c_COLS);
                    w_first_wen = 1'b1;
                    w_line      = r_first;
                    w_clr_addr  = r_first;
                    w_clr_cnt   = c_COLS;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_init       <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_first      <= '0;
            r_line       <= '0;
            r_clr_addr   <= '0;
            r_clr_cnt    <= '0;
            r_char       <= '0;
            r_addr       <= '0;
            r_char_wen   <= 1'b0;
            r_first_wen  <= 1'b0;
            r_cursor_wen <= 1'b0;
            r_bell       <= 1'b0;
        end else begin
            r_init       <= 1'b1;
            r_x          <= w_x;
            r_y          <= w_y;
            r_first      <= w_first;
            r_line       <= w_line;
            r_clr_addr   <= w_clr_addr;
            r_clr_cnt    <= w_clr_cnt;
            r_char       <= w_char;
            r_addr       <= w_addr;
            r_char_wen   <= w_char_wen;
            r_first_wen  <= w_first_wen;
            r_cursor_wen <= w_cursor_wen;
            r_bell       <= w_bell;
        end
    end

    always_comb begin
        in_ready = r_init && (r_state == c_IDLE);
    end

    assign new_char           = r_char;
    assign new_char_address   = r_addr;
    assign new_char_wen       = r_char_wen;
    assign new_first_char     = r_first;
    assign new_first_char_wen = r_first_wen;
    assign new_cursor_x       = r_x;
    assign new_cursor_y       = r_y;
    assign new_cursor_wen     = r_cursor_wen;
    assign bell               = r_bell;

endmodule
`default_nettype wire

// File: tb/tb_tty_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tty_writer
//  Description : Self-checking bench for tty_writer (scoreboarded buffer writes).
//  Revision    : 1.0
// ============================================================================
module tb_tty_writer;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  new_char;
    logic [10:0] new_char_address;
    logic        new_char_wen;
    logic [10:0] new_first_char;
    logic        new_first_char_wen;
    logic [6:0]  new_cursor_x;
    logic [4:0]  new_cursor_y;
    logic        new_cursor_wen;
    logic        bell;

    logic [7:0]  b_in_data = 8'h00;
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [7:0]  b_char;
    logic [10:0] b_addr;
    logic        b_char_wen;
    logic [10:0] b_first;
    logic        b_first_wen;
    logic [6:0]  b_x;
    logic [4:0]  b_y;
    logic        b_cursor_wen;
    logic        b_bell;

    int tests = 0;
    int fails = 0;
    logic [18:0] exp_q[$];

    always #5 clk = ~clk;

    tty_writer dut (
        .clk(clk), .clr(clr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .new_char(new_char), .new_char_address(new_char_address), .new_char_wen(new_char_wen),
        .new_first_char(new_first_char), .new_first_char_wen(new_first_char_wen),
        .new_cursor_x(new_cursor_x), .new_cursor_y(new_cursor_y), .new_cursor_wen(new_cursor_wen),
        .bell(bell)
    );

    tty_writer #(.AUTOWRAP(1'b0), .CLEAR_ON_RESET(1'b0)) dut_nw (
        .clk(clk), .clr(clr), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .new_char(b_char), .new_char_address(b_addr), .new_char_wen(b_char_wen),
        .new_first_char(b_first), .new_first_char_wen(b_first_wen),
        .new_cursor_x(b_x), .new_cursor_y(b_y), .new_cursor_wen(b_cursor_wen),
        .bell(b_bell)
    );

    // Scoreboard: every buffer write of the main DUT must match the head of the queue.
    always @(negedge clk) begin
        if (new_char_wen) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL char_write: got addr %0d data %h, expected no write", new_char_address, new_char);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                if ({new_char_address, new_char} !== e) begin
                    fails++;
                    $display("FAIL char_write: got addr %0d data %h, expected addr %0d data %h",
                             new_char_address, new_char, e[18:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_spaces(input int base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({11'((base + i) % 1920), 8'h20});
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 5000) begin @(negedge clk); n++; end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready=%b, expected 1", in_ready);
        end
        in_data = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        @(negedge clk);
        b_in_data = b; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    // Counts edges until in_ready rises, then lets the scoreboard drain the last write.
    task automatic wait_idle(input string tag, input int expected);
        int n = 0;
        while (!in_ready && n < 3000) begin @(posedge clk); #1; n++; end
        @(negedge clk); #1;
        tests++;
        if (n !== expected) begin
            fails++;
            $display("FAIL %s_clear_cycles: got %0d, expected %0d", tag, n, expected);
        end
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL %s_pending_writes: got %0d outstanding, expected 0", tag, exp_q.size());
        end
    endtask

    task automatic release_and_clear(input string tag);
        push_spaces(0, 1920);
        @(negedge clk); clr = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({new_first_char_wen, new_cursor_wen, new_char_wen, in_ready} !== 4'b1100) begin
            fails++;
            $display("FAIL %s_first_edge: fwen/cwen/chwen/rdy=%b, expected 1100", tag,
                     {new_first_char_wen, new_cursor_wen, new_char_wen, in_ready});
        end
        tests++;
        if ({b_in_ready, b_first_wen, b_cursor_wen, b_char_wen} !== 4'b1000) begin
            fails++;
            $display("FAIL %s_noclear_first_edge: rdy/fwen/cwen/chwen=%b, expected 1000", tag,
                     {b_in_ready, b_first_wen, b_cursor_wen, b_char_wen});
        end
        wait_idle(tag, 1920);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({new_char_wen, new_first_char_wen, new_cursor_wen, bell, in_ready, new_char,
             new_char_address, new_first_char, new_cursor_x, new_cursor_y} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%b char=%h addr=%0d first=%0d x=%0d y=%0d, expected all 0",
                     in_ready, new_char, new_char_address, new_first_char, new_cursor_x, new_cursor_y);
        end
        release_and_clear("reset");
    endtask

    task automatic test_print_ab();
        exp_q.push_back({11'd0, 8'h41});
        exp_q.push_back({11'd1, 8'h42});
        send(8'h41);
        tests++;
        if ({new_cursor_wen, new_cursor_x, new_cursor_y} !== {1'b1, 7'd1, 5'd0}) begin
            fails++;
            $display("FAIL print_A_cursor: wen=%b x=%0d y=%0d, expected 1 1 0", new_cursor_wen, new_cursor_x, new_cursor_y);
        end
        send(8'h42);
        tests++;
        if ({new_cursor_wen, new_cursor_x, new_cursor_y, new_first_char_wen} !== {1'b1, 7'd2, 5'd0, 1'b0}) begin
            fails++;
            $display("FAIL print_B_cursor: wen=%b x=%0d y=%0d fwen=%b, expected 1 2 0 0",
                     new_cursor_wen, new_cursor_x, new_cursor_y, new_first_char_wen);
        end
        @(posedge clk); #1;
        tests++;
        if ({new_cursor_wen, new_char_wen} !== 2'b00) begin
            fails++;
            $display("FAIL pulse_width: cwen/chwen=%b one cycle later, expected 00", {new_cursor_wen, new_char_wen});
        end
    endtask

    task automatic test_control();
        send(8'h0D);
        tests++;
        if ({new_cursor_wen, new_cursor_x} !== {1'b1, 7'd0}) begin
            fails++;
            $display("FAIL cr: wen=%b x=%0d, expected 1 0", new_cursor_wen, new_cursor_x);
        end
        send(8'h08);
        tests++;
        if ({new_cursor_wen, new_cursor_x} !== {1'b1, 7'd0}) begin
            fails++;
            $display("FAIL bs_at_0: wen=%b x=%0d, expected 1 0", new_cursor_wen, new_cursor_x);
        end
        exp_q.push_back({11'd0, 8'h58});
        send(8'h58);
        send(8'h08);
        tests++;
        if (new_cursor_x !== 7'd0) begin
            fails++;
            $display("FAIL bs_move: x=%0d, expected 0", new_cursor_x);
        end
        send(8'h0A);
        tests++;
        if ({new_cursor_wen, new_cursor_x, new_cursor_y, new_first_char_wen} !== {1'b1, 7'd0, 5'd1, 1'b0}) begin
            fails++;
            $display("FAIL lf: wen=%b x=%0d y=%0d fwen=%b, expected 1 0 1 0",
                     new_cursor_wen, new_cursor_x, new_cursor_y, new_first_char_wen);
        end
        send(8'h07);
        tests++;
        if ({bell, new_cursor_wen, new_char_wen, new_first_char_wen} !== 4'b1000) begin
            fails++;
            $display("FAIL bel: bell/cwen/chwen/fwen=%b, expected 1000", {bell, new_cursor_wen, new_char_wen, new_first_char_wen});
        end
        send(8'h01);
        tests++;
        if ({bell, new_cursor_wen, new_char_wen, new_first_char_wen} !== 4'b0000) begin
            fails++;
            $display("FAIL ignore_01: bell/cwen/chwen/fwen=%b, expected 0000", {bell, new_cursor_wen, new_char_wen, new_first_char_wen});
        end
        send(8'h7F);
        tests++;
        if ({bell, new_cursor_wen, new_char_wen, new_first_char_wen} !== 4'b0000) begin
            fails++;
            $display("FAIL ignore_7f: bell/cwen/chwen/fwen=%b, expected 0000", {bell, new_cursor_wen, new_char_wen, new_first_char_wen});
        end
    endtask

    task automatic test_autowrap_scroll();
        for (int i = 0; i < 22; i++) send(8'h0A);
        tests++;
        if ({new_cursor_x, new_cursor_y} !== {7'd0, 5'd23}) begin
            fails++;
            $display("FAIL lf_to_bottom: x=%0d y=%0d, expected 0 23", new_cursor_x, new_cursor_y);
        end
        for (int i = 0; i < 79; i++) exp_q.push_back({11'(1840 + i), 8'h61});
        for (int i = 0; i < 79; i++) send(8'h61);
        exp_q.push_back({11'd1919, 8'h5A});
        push_spaces(0, 80);
        send(8'h5A);
        tests++;
        if ({new_char_wen, new_first_char_wen, new_cursor_wen, in_ready, new_first_char, new_cursor_x, new_cursor_y}
            !== {4'b1110, 11'd80, 7'd0, 5'd23}) begin
            fails++;
            $display("FAIL wrap_scroll: chwen/fwen/cwen/rdy=%b first=%0d x=%0d y=%0d, expected 1110 80 0 23",
                     {new_char_wen, new_first_char_wen, new_cursor_wen, in_ready}, new_first_char, new_cursor_x, new_cursor_y);
        end
        wait_idle("wrap_scroll", 80);
        exp_q.push_back({11'd0, 8'h4D});
        send(8'h4D);
        tests++;
        if (new_char_address !== 11'd0) begin
            fails++;
            $display("FAIL cell_mod_wrap: addr=%0d, expected 0", new_char_address);
        end
    endtask

    task automatic test_scroll_wrap();
        for (int k = 0; k < 22; k++) begin
            push_spaces(80 + 80 * k, 80);
            send(8'h0A);
            wait_idle("scroll_loop", 80);
        end
        tests++;
        if (new_first_char !== 11'd1840) begin
            fails++;
            $display("FAIL scroll_accum: first=%0d, expected 1840", new_first_char);
        end
        push_spaces(1840, 80);
        send(8'h0A);
        tests++;
        if ({new_first_char_wen, new_cursor_wen, new_first_char, new_cursor_x, new_cursor_y}
            !== {2'b11, 11'd0, 7'd1, 5'd23}) begin
            fails++;
            $display("FAIL first_char_wrap: fwen/cwen=%b first=%0d x=%0d y=%0d, expected 11 0 1 23",
                     {new_first_char_wen, new_cursor_wen}, new_first_char, new_cursor_x, new_cursor_y);
        end
        wait_idle("first_char_wrap", 80);
        exp_q.push_back({11'd1841, 8'h50});
        send(8'h50);
    endtask

    task automatic test_clr_mid_clear();
        push_spaces(0, 80);
        send(8'h0A);
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        clr = 1'b1;
        #1;
        tests++;
        if ({new_char_wen, new_first_char_wen, new_cursor_wen, bell, in_ready, new_char,
             new_char_address, new_first_char, new_cursor_x, new_cursor_y} !== '0) begin
            fails++;
            $display("FAIL abort_outputs: chwen=%b ready=%b first=%0d x=%0d y=%0d addr=%0d, expected all 0",
                     new_char_wen, in_ready, new_first_char, new_cursor_x, new_cursor_y, new_char_address);
        end
        tests++;
        if (exp_q.size() !== 70) begin
            fails++;
            $display("FAIL abort_write_count: got %0d outstanding, expected 70", exp_q.size());
        end
        exp_q.delete();
        repeat (3) begin @(posedge clk); #1; end
        tests++;
        if ({new_char_wen, in_ready} !== 2'b00) begin
            fails++;
            $display("FAIL abort_hold: chwen/rdy=%b, expected 00", {new_char_wen, in_ready});
        end
        release_and_clear("restart");
    endtask

    task automatic test_form_feed();
        exp_q.push_back({11'd0, 8'h46});
        send(8'h46);
        send(8'h0A);
        exp_q.push_back({11'd81, 8'h47});
        send(8'h47);
        push_spaces(0, 1920);
        send(8'h0C);
        tests++;
        if ({new_first_char_wen, new_cursor_wen, new_char_wen, in_ready, new_first_char, new_cursor_x, new_cursor_y}
            !== {4'b1100, 11'd0, 7'd0, 5'd0}) begin
            fails++;
            $display("FAIL form_feed: fwen/cwen/chwen/rdy=%b first=%0d x=%0d y=%0d, expected 1100 0 0 0",
                     {new_first_char_wen, new_cursor_wen, new_char_wen, in_ready}, new_first_char, new_cursor_x, new_cursor_y);
        end
        wait_idle("form_feed", 1920);
    endtask

    task automatic test_no_autowrap();
        for (int i = 0; i < 79; i++) send_b(8'h71);
        send_b(8'h51);
        tests++;
        if ({b_char_wen, b_char, b_addr, b_cursor_wen, b_x, b_y, b_first_wen}
            !== {1'b1, 8'h51, 11'd79, 1'b1, 7'd79, 5'd0, 1'b0}) begin
            fails++;
            $display("FAIL noautowrap_last_col: chwen=%b char=%h addr=%0d cwen=%b x=%0d y=%0d fwen=%b, expected 1 51 79 1 79 0 0",
                     b_char_wen, b_char, b_addr, b_cursor_wen, b_x, b_y, b_first_wen);
        end
        send_b(8'h0D);
        send_b(8'h08);
        tests++;
        if ({b_cursor_wen, b_x, b_y} !== {1'b1, 7'd0, 5'd0}) begin
            fails++;
            $display("FAIL noautowrap_bs_at_0: cwen=%b x=%0d y=%0d, expected 1 0 0", b_cursor_wen, b_x, b_y);
        end
    endtask

    initial begin
        test_reset();
        test_print_ab();
        test_control();
        test_autowrap_scroll();
        test_scroll_wrap();
        test_clr_mid_clear();
        test_form_feed();
        test_no_autowrap();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tty_writer.md
TTY_WRITER -- requirements
Module: tty_writer

Interface
REQ-001 Parameter ROWS, default 24, number of text rows.
REQ-002 Parameter COLS, default 80, number of text columns.
REQ-003 Parameters ROW_BITS 5, COL_BITS 7, ADDR_BITS 11, the widths of row, column and buffer address; ROWS*COLS SHALL fit in ADDR_BITS.
REQ-004 Parameter AUTOWRAP, default 1: a printable character in the last column wraps to the next line.
REQ-005 Parameter CLEAR_ON_RESET, default 1: the buffer is cleared after reset release.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 clr  in  1  reset, asynchronous, active-high.
REQ-008 in_data/in_valid/in_ready  in/in/out  8/1/1  byte stream; a byte transfers on an edge where valid and ready are both high.
REQ-009 new_char/new_char_address/new_char_wen  out  8/ADDR_BITS/1  character buffer write port.
REQ-010 new_first_char/new_first_char_wen  out  ADDR_BITS/1  scroll origin write port.
REQ-011 new_cursor_x/new_cursor_y/new_cursor_wen  out  COL_BITS/ROW_BITS/1  cursor position write port.
REQ-012 bell  out  1  one-cycle pulse on BEL.

Function
REQ-013 The buffer SHALL be circular, SIZE=ROWS*COLS; cell (x,y) address = (first_char + y*COLS + x) mod SIZE, via an incrementally maintained line-start register; no multiplier.
REQ-014 States: IDLE, CLEAR_LINE, CLEAR_SCREEN; in_ready SHALL be 1 only in IDLE.
REQ-015 Latency: a byte accepted at edge N SHALL have all of its wen/bell pulses asserted in the cycle after edge N, each for exactly one cycle.
REQ-016 Bytes 0x20-0x7E: write the byte at the cursor, then x+1; new_cursor_wen=1.
REQ-017 Last column, AUTOWRAP=1: write the byte, then x=0 and line feed; AUTOWRAP=0: write the byte, cursor unchanged, new_cursor_wen=1.
REQ-018 0x0D: x=0. 0x08: x-1 when x>0, else no move. Both pulse new_cursor_wen.
REQ-019 0x0A with y<ROWS-1: y+1, x unchanged, new_cursor_wen pulse.
REQ-020 0x0A with y=ROWS-1 (scroll): first_char=(first_char+COLS) mod SIZE, new_first_char_wen and new_cursor_wen pulse at edge N, y stays ROWS-1; enter CLEAR_LINE.
REQ-021 CLEAR_LINE: edges N+1..N+COLS write 0x20 to addresses old_first_char..old_first_char+COLS-1 mod SIZE, one per cycle; return to IDLE after the last write.
REQ-022 0x0C: first_char=0 and cursor (0,0), with both wen pulses at edge N; CLEAR_SCREEN writes 0x20 to addresses 0..SIZE-1 on edges N+1..N+SIZE, then IDLE.
REQ-023 0x07: bell pulse, with no other effect.
REQ-024 All other bytes: accepted and ignored, with no pulses.
REQ-025 Wrap from the last column on the last row: the character write, scroll and cursor pulses SHALL all occur in the same cycle.
REQ-026 Address and first_char sums SHALL wrap modulo SIZE (subtract SIZE when the sum >= SIZE), never modulo 2^ADDR_BITS.

Reset
REQ-027 While clr=1: all wen/bell=0, in_ready=0, cursor (0,0), first_char=0, all data/address outputs 0, state IDLE.
REQ-028 clr asserted mid-CLEAR_LINE or mid-CLEAR_SCREEN SHALL abort immediately, with no further writes.
REQ-029 After release, CLEAR_ON_RESET=1: enter CLEAR_SCREEN on the first edge (first_char and cursor wen pulses), in_ready=0 until SIZE writes finish; CLEAR_ON_RESET=0: IDLE with in_ready=1 on the first edge.

Verification
REQ-030 Reset release, defaults -> 1920 writes of 0x20 to addresses 0..1919 in order, then in_ready=1.
REQ-031 "A","B" from (0,0) -> writes 0x41@0 and 0x42@1, cursor (2,0) with one new_cursor_wen per byte.
REQ-032 Cursor (79,23), first_char 0, "Z" -> write 0x5A@1919, first_char 80, cursor (0,23), then 80 writes of 0x20@0..79 with in_ready=0.
REQ-033 first_char 1840, y=23, 0x0A -> first_char 0 (mod wrap), spaces @1840..1919.
REQ-034 AUTOWRAP=0, x=79, "Q" -> write @x=79, cursor stays (79,y); 0x08 at x=0 -> cursor unchanged.
REQ-035 clr pulsed mid-CLEAR_LINE -> writes stop, outputs match REQ-027, then the REQ-029 sequence restarts.
